// File: rtl/parking_occupancy_arbiter_pkg.sv
// Shared types for the parking occupancy arbiter: lot FSM encoding and slot numbering.
// Slot ordering is lane0.enter, lane0.exit, lane1.enter, lane1.exit, ...
package parking_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      OPEN  = 2'd1,
      FULL  = 2'd2
   } occ_state_e;

   localparam int SLOT_ENTER = 0;
   localparam int SLOT_EXIT  = 1;

   function automatic int slot_idx(input int lane, input int is_exit);
      return lane * 2 + is_exit;
   endfunction

endpackage

// File: rtl/parking_occupancy_arbiter_if.sv
// Lane request / occupancy status bundle between the lane FSMs and the arbiter.
// reject_count exists only when PARKING_REJECT_STATS_EN is defined.
interface parking_occupancy_arbiter_if #(
   parameter int NUM_LANES = 2,
   parameter int CNT_BITS  = 8
);
   import parking_pkg::*;

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   // Requests are 1-cycle pulses with no ready: the arbiter always accepts them and
   // latches them as pending; the strobes below are 1-cycle results with no back-pressure.
   logic [NUM_LANES-1:0] enter_req;
   logic [NUM_LANES-1:0] exit_req;
   logic                 clear_err;
   logic [CNT_BITS-1:0]  occupancy;
   logic                 full;
   logic                 empty;
   logic                 cnt_en;
   logic                 cnt_up;
   logic [LANE_W-1:0]    grant_lane;
   logic                 reject;
   logic                 underflow_err;
   logic                 overrun_err;
   occ_state_e           state;
`ifdef PARKING_REJECT_STATS_EN
   logic [7:0]           reject_count;
`endif

   modport master (
      output enter_req, exit_req, clear_err,
`ifdef PARKING_REJECT_STATS_EN
      input  reject_count,
`endif
      input  occupancy, full, empty, cnt_en, cnt_up, grant_lane,
      input  reject, underflow_err, overrun_err, state
   );

   modport slave (
      input  enter_req, exit_req, clear_err,
`ifdef PARKING_REJECT_STATS_EN
      output reject_count,
`endif
      output occupancy, full, empty, cnt_en, cnt_up, grant_lane,
      output reject, underflow_err, overrun_err, state
   );

endinterface

// File: rtl/parking_occupancy_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first pending slot at or after rr_ptr_i, wrapping.
// The pointer register is owned by the parent.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  pending_i,
   input  logic [PW-1:0] rr_ptr_i,
   output logic          grant_valid_o,
   output logic [PW-1:0] grant_idx_o
);

   int idx;

   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      idx           = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr_i) + k;
         if (idx >= N) idx = idx - N;
         if (!grant_valid_o && pending_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/parking_occupancy_arbiter.sv
// Shares one lot-occupancy counter between NUM_LANES lanes, one granted event per cycle.
// Optional feature macro: PARKING_REJECT_STATS_EN adds a saturating reject counter.
module parking_occupancy_arbiter
   import parking_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int CNT_BITS  = 8,
   parameter int CAPACITY  = 200
) (
   input logic                        clk,
   input logic                        reset_n,
   parking_occupancy_arbiter_if.slave bus
);

   localparam int NSLOT  = 2 * NUM_LANES;
   localparam int PW     = $clog2(NSLOT);
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [CNT_BITS-1:0] CAP = CNT_BITS'(CAPACITY);

   logic [NSLOT-1:0]    pending_q, pending_d, req_vec, grant_mask;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d, grant_idx;
   logic                grant_valid, grant_is_exit;
   logic [LANE_W-1:0]   grant_lane_w;
   logic [CNT_BITS-1:0] occ_q, occ_d;
   occ_state_e          state_q, state_d;
   logic                cnt_en_q, cnt_en_d, cnt_up_q, cnt_up_d, reject_q, reject_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic                underflow_q, underflow_d, underflow_set;
   logic                overrun_q, overrun_d, overrun_set;

   always_comb begin
      req_vec = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         req_vec[slot_idx(l, SLOT_ENTER)] = bus.enter_req[l];
         req_vec[slot_idx(l, SLOT_EXIT)]  = bus.exit_req[l];
      end
   end

   rr_arbiter #(.N(NSLOT), .PW(PW)) u_rr_arbiter (
      .pending_i     (pending_q),
      .rr_ptr_i      (rr_ptr_q),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
   );

   assign grant_is_exit = grant_idx[0];
   assign grant_lane_w  = LANE_W'(grant_idx >> 1);
   assign grant_mask    = grant_valid ? (NSLOT'(1) << grant_idx) : '0;

   // A pulse on the slot being granted this edge re-arms it instead of counting as overrun.
   always_comb begin
      pending_d   = (pending_q & ~grant_mask) | req_vec;
      overrun_set = |(req_vec & pending_q & ~grant_mask);
      rr_ptr_d    = rr_ptr_q;
      if (grant_valid) begin
         rr_ptr_d = (int'(grant_idx) == NSLOT - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   always_comb begin
      occ_d         = occ_q;
      cnt_en_d      = 1'b0;
      cnt_up_d      = 1'b0;
      reject_d      = 1'b0;
      lane_d        = lane_q;
      underflow_set = 1'b0;
      if (grant_valid) begin
         lane_d = grant_lane_w;
         if (!grant_is_exit) begin
            if (state_q == FULL) begin
               reject_d = 1'b1;
            end else begin
               occ_d    = occ_q + 1'b1;
               cnt_en_d = 1'b1;
               cnt_up_d = 1'b1;
            end
         end else begin
            if (state_q == EMPTY) begin
               underflow_set = 1'b1;
            end else begin
               occ_d    = occ_q - 1'b1;
               cnt_en_d = 1'b1;
            end
         end
      end

      // With CAPACITY == 1 the EMPTY and FULL states step directly into each other.
      state_d = state_q;
      case (state_q)
         EMPTY:   if (occ_d != '0) state_d = (occ_d == CAP) ? FULL : OPEN;
         OPEN:    if (occ_d == CAP) state_d = FULL;
                  else if (occ_d == '0) state_d = EMPTY;
         FULL:    if (occ_d != CAP) state_d = (occ_d == '0) ? EMPTY : OPEN;
         default: state_d = EMPTY;
      endcase

      underflow_d = bus.clear_err ? 1'b0 : (underflow_q | underflow_set);
      overrun_d   = bus.clear_err ? 1'b0 : (overrun_q | overrun_set);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q   <= '0;
         rr_ptr_q    <= '0;
         occ_q       <= '0;
         state_q     <= EMPTY;
         cnt_en_q    <= 1'b0;
         cnt_up_q    <= 1'b0;
         reject_q    <= 1'b0;
         lane_q      <= '0;
         underflow_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         rr_ptr_q    <= rr_ptr_d;
         occ_q       <= occ_d;
         state_q     <= state_d;
         cnt_en_q    <= cnt_en_d;
         cnt_up_q    <= cnt_up_d;
         reject_q    <= reject_d;
         lane_q      <= lane_d;
         underflow_q <= underflow_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef PARKING_REJECT_STATS_EN
   logic [7:0] rej_cnt_q, rej_cnt_d;

   always_comb begin
      rej_cnt_d = rej_cnt_q;
      if (bus.clear_err)                          rej_cnt_d = '0;
      else if (reject_d && rej_cnt_q != 8'hFF)   rej_cnt_d = rej_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rej_cnt_q <= '0;
      else          rej_cnt_q <= rej_cnt_d;
   end

   assign bus.reject_count = rej_cnt_q;
`endif

   assign bus.occupancy     = occ_q;
   assign bus.full          = (state_q == FULL);
   assign bus.empty         = (state_q == EMPTY);
   assign bus.cnt_en        = cnt_en_q;
   assign bus.cnt_up        = cnt_up_q;
   assign bus.grant_lane    = lane_q;
   assign bus.reject        = reject_q;
   assign bus.underflow_err = underflow_q;
   assign bus.overrun_err   = overrun_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_parking_occupancy_arbiter.sv
// Directed bench for parking_occupancy_arbiter: a CAPACITY=200 instance and a CAPACITY=3 instance.
// Honours PARKING_REJECT_STATS_EN when checking reject_count.
module tb_parking_occupancy_arbiter;
   import parking_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   parking_occupancy_arbiter_if #(.NUM_LANES(2), .CNT_BITS(8)) if_a ();
   parking_occupancy_arbiter_if #(.NUM_LANES(2), .CNT_BITS(8)) if_b ();

   parking_occupancy_arbiter #(.NUM_LANES(2), .CNT_BITS(8), .CAPACITY(200)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if_a)
   );

   parking_occupancy_arbiter #(.NUM_LANES(2), .CNT_BITS(8), .CAPACITY(3)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if_b)
   );

   int checks = 0;
   int errors = 0;
   // Scoreboard entry: {reject, cnt_up, grant_lane, occupancy}
   logic [10:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit strobe(input bit sel);
      if (sel) return if_b.cnt_en | if_b.reject;
      return if_a.cnt_en | if_a.reject;
   endfunction

   function automatic logic [10:0] obs_evt(input bit sel);
      if (sel) return {if_b.reject, if_b.cnt_up, if_b.grant_lane, if_b.occupancy};
      return {if_a.reject, if_a.cnt_up, if_a.grant_lane, if_a.occupancy};
   endfunction

   task automatic push(input logic rej, input logic up, input logic lane, input logic [7:0] occ);
      exp_q.push_back({rej, up, lane, occ});
   endtask

   // Starts at a negedge; holds the pulse across exactly one rising edge.
   task automatic drive(input bit sel, input logic [1:0] en, input logic [1:0] ex);
      if (sel) begin if_b.enter_req = en; if_b.exit_req = ex; end
      else     begin if_a.enter_req = en; if_a.exit_req = ex; end
      @(negedge clk);
      if (sel) begin if_b.enter_req = '0; if_b.exit_req = '0; end
      else     begin if_a.enter_req = '0; if_a.exit_req = '0; end
   endtask

   // Checks the current negedge first, then up to budget further negedges.
   task automatic wait_event(input bit sel, input int budget, input string tag);
      logic [10:0] exp;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $error("FAIL %s: observed=strobe expected=empty scoreboard", tag);
         return;
      end
      exp = exp_q.pop_front();
      for (int i = 0; i <= budget; i++) begin
         if (strobe(sel)) begin
            check(tag, 32'(obs_evt(sel)), 32'(exp));
            return;
         end
         if (i < budget) @(negedge clk);
      end
      checks++; errors++;
      $error("FAIL %s: observed=no strobe expected=%0h", tag, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_strobe;
      reset_n = 1'b0;
      if_a.enter_req = '0; if_a.exit_req = '0; if_a.clear_err = 1'b0;
      if_b.enter_req = '0; if_b.exit_req = '0; if_b.clear_err = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check("rst_occ",    32'(if_a.occupancy), 32'd0);
      check("rst_empty",  32'(if_a.empty), 32'd1);
      check("rst_full",   32'(if_a.full), 32'd0);
      check("rst_strobe", 32'(strobe(1'b0)), 32'd0);
      check("rst_errs",   32'({if_a.underflow_err, if_a.overrun_err}), 32'd0);
      check("rst_state",  32'(if_a.state), 32'(EMPTY));

      // Single lane0 enter: 0 -> 1 two edges after the pulse
      push(1'b0, 1'b1, 1'b0, 8'd1);
      drive(1'b0, 2'b01, 2'b00);
      wait_event(1'b0, 6, "t1_enter");
      check("t1_empty", 32'(if_a.empty), 32'd0);
      check("t1_state", 32'(if_a.state), 32'(OPEN));

      // Build to 5, leaving rr_ptr at 0 via a lane1 exit
      for (int k = 2; k <= 5; k++) begin
         push(1'b0, 1'b1, 1'b0, 8'(k));
         drive(1'b0, 2'b01, 2'b00);
         wait_event(1'b0, 6, "t2_build");
      end
      push(1'b0, 1'b1, 1'b1, 8'd6);
      drive(1'b0, 2'b10, 2'b00);
      wait_event(1'b0, 6, "t2_l1_enter");
      push(1'b0, 1'b0, 1'b1, 8'd5);
      drive(1'b0, 2'b00, 2'b10);
      wait_event(1'b0, 6, "t2_l1_exit");

      // Both lanes enter together: back-to-back grants, lane0 first
      push(1'b0, 1'b1, 1'b0, 8'd6);
      push(1'b0, 1'b1, 1'b1, 8'd7);
      drive(1'b0, 2'b11, 2'b00);
      wait_event(1'b0, 4, "t2_first");
      @(negedge clk);
      wait_event(1'b0, 0, "t2_second");
      check("t2_occ", 32'(if_a.occupancy), 32'd7);
      check("t2_no_overrun", 32'(if_a.overrun_err), 32'd0);

      // Lane1 enter re-pulsed while lane0 events win arbitration (rr_ptr=3)
      push(1'b0, 1'b1, 1'b0, 8'd8);
      push(1'b0, 1'b0, 1'b0, 8'd7);
      push(1'b0, 1'b1, 1'b1, 8'd8);
      if_a.enter_req = 2'b11; if_a.exit_req = 2'b01;
      @(negedge clk);
      if_a.enter_req = 2'b10; if_a.exit_req = 2'b00;
      @(negedge clk);
      if_a.enter_req = 2'b00;
      wait_event(1'b0, 0, "t5_l0_enter");
      @(negedge clk);
      wait_event(1'b0, 0, "t5_l0_exit");
      @(negedge clk);
      wait_event(1'b0, 0, "t5_l1_enter");
      check("t5_overrun", 32'(if_a.overrun_err), 32'd1);
      n_strobe = 0;
      repeat (6) begin
         @(negedge clk);
         if (strobe(1'b0)) n_strobe++;
      end
      check("t5_extra_grants", 32'(n_strobe), 32'd0);
      check("t5_occ", 32'(if_a.occupancy), 32'd8);

      // Async reset with three pending events
      if_a.enter_req = 2'b11; if_a.exit_req = 2'b01;
      @(negedge clk);
      if_a.enter_req = 2'b00; if_a.exit_req = 2'b00;
      #2 reset_n = 1'b0;
      #1;
      check("t6_occ",    32'(if_a.occupancy), 32'd0);
      check("t6_empty",  32'(if_a.empty), 32'd1);
      check("t6_full",   32'(if_a.full), 32'd0);
      check("t6_strobe", 32'(strobe(1'b0)), 32'd0);
      check("t6_errs",   32'({if_a.underflow_err, if_a.overrun_err}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      n_strobe = 0;
      repeat (8) begin
         @(negedge clk);
         if (strobe(1'b0)) n_strobe++;
      end
      check("t6_no_grant", 32'(n_strobe), 32'd0);
      check("t6_occ_after", 32'(if_a.occupancy), 32'd0);

      // CAPACITY=3 instance: exit while empty, then clear_err
      drive(1'b1, 2'b00, 2'b01);
      repeat (3) @(negedge clk);
      check("t4_underflow", 32'(if_b.underflow_err), 32'd1);
      check("t4_occ", 32'(if_b.occupancy), 32'd0);
      if_b.clear_err = 1'b1;
      @(negedge clk);
      if_b.clear_err = 1'b0;
      check("t4_cleared", 32'(if_b.underflow_err), 32'd0);

      // Fill to capacity, then one rejected enter
      for (int k = 1; k <= 3; k++) begin
         push(1'b0, 1'b1, 1'b0, 8'(k));
         drive(1'b1, 2'b01, 2'b00);
         wait_event(1'b1, 6, "t3_fill");
      end
      check("t3_full", 32'(if_b.full), 32'd1);
      check("t3_state", 32'(if_b.state), 32'(FULL));
      push(1'b1, 1'b0, 1'b0, 8'd3);
      drive(1'b1, 2'b01, 2'b00);
      wait_event(1'b1, 6, "t3_reject");
      check("t3_occ", 32'(if_b.occupancy), 32'd3);
      check("t3_cnt_en", 32'(if_b.cnt_en), 32'd0);
`ifdef PARKING_REJECT_STATS_EN
      check("t3_reject_count", 32'(if_b.reject_count), 32'd1);
      if_b.clear_err = 1'b1;
      @(negedge clk);
      if_b.clear_err = 1'b0;
      check("t3_reject_count_clr", 32'(if_b.reject_count), 32'd0);
`endif
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
